// File: rtl/card_rom_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : card_rom_arbiter_if
//  Description : Bundles the requester-side and ROM-side signals of the card
//                ROM arbiter. The slave modport is the arbiter's view; the
//                master modport is the view of the renderers plus the ROM.
//  Revision    : 1.0 - initial release
// ============================================================================
interface card_rom_arbiter_if #(
    parameter int N_REQ      = 4,
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 12
);
    logic [N_REQ-1:0]            req;
    logic [N_REQ*ADDR_WIDTH-1:0] addr;
    logic [N_REQ-1:0]            gnt;
    logic [ADDR_WIDTH-1:0]       rom_addr;
    logic [DATA_WIDTH-1:0]       rom_dout;
    logic [DATA_WIDTH-1:0]       rdata;
    logic [N_REQ-1:0]            rvalid;

    modport slave (
        input  req, addr, rom_dout,
        output gnt, rom_addr, rdata, rvalid
    );

    modport master (
        output req, addr, rom_dout,
        input  gnt, rom_addr, rdata, rvalid
    );
endinterface
`default_nettype wire

// File: rtl/card_rom_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : card_rom_arbiter
//  Description : Round-robin arbiter sharing one registered-output card image
//                ROM among N_REQ sprite renderers. Grant is combinational;
//                read data returns 3 cycles later with a one-hot rvalid tag.
//                Define CARD_ARB_FIXED_PRIO_EN for fixed lowest-index-wins
//                priority instead of round-robin.
//  Revision    : 1.0 - initial release
// ============================================================================
module card_rom_arbiter #(
    parameter int N_REQ      = 4,
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 12
) (
    input  logic               clk,
    input  logic               rst_n,
    card_rom_arbiter_if.slave  bus
);

    localparam int c_PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [c_PTR_W-1:0]    w_base;
    logic [c_PTR_W-1:0]    w_win;
    logic                  w_any;
    logic [N_REQ-1:0]      w_gnt;
    logic [ADDR_WIDTH-1:0] w_sel_addr;

    logic [ADDR_WIDTH-1:0] r_rom_addr;
    logic [N_REQ-1:0]      r_tag1;
    logic [N_REQ-1:0]      r_tag2;
    logic [N_REQ-1:0]      r_rvalid;
    logic [DATA_WIDTH-1:0] r_rdata;

    // Reduce a search position to a requester index.
    function automatic logic [c_PTR_W-1:0] f_wrap(input int v);
        int r;
        r = v % N_REQ;
        return r[c_PTR_W-1:0];
    endfunction

`ifdef CARD_ARB_FIXED_PRIO_EN
    // Fixed priority: the search always starts at requester 0.
    assign w_base = '0;
`else
    logic [c_PTR_W-1:0] r_ptr;
    logic [c_PTR_W-1:0] w_ptr_nxt;

    assign w_ptr_nxt = (w_win == c_PTR_W'(N_REQ - 1)) ? '0 : w_win + 1'b1;
    assign w_base    = r_ptr;

    // Round-robin pointer: moves just past the winner, holds when idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (w_any) begin
            r_ptr <= w_ptr_nxt;
        end
    end
`endif

    // Search req from the base index with wrap-around; first set bit wins.
    always_comb begin
        w_any = 1'b0;
        w_win = '0;
        w_gnt = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!w_any && bus.req[f_wrap(int'(w_base) + k)]) begin
                w_any = 1'b1;
                w_win = f_wrap(int'(w_base) + k);
            end
        end
        if (w_any) begin
            w_gnt[w_win] = 1'b1;
        end
    end

    // Pick the address slice of the granted requester.
    always_comb begin
        w_sel_addr = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_gnt[i]) begin
                w_sel_addr = bus.addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            end
        end
    end

    // Three-stage read pipeline: address/tag, ROM latency, output capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rom_addr <= '0;
            r_tag1     <= '0;
            r_tag2     <= '0;
            r_rvalid   <= '0;
            r_rdata    <= '0;
        end else begin
            if (w_any) begin
                r_rom_addr <= w_sel_addr;
            end
            r_tag1   <= w_gnt;
            r_tag2   <= r_tag1;
            r_rvalid <= r_tag2;
            if (|r_tag2) begin
                r_rdata <= bus.rom_dout;
            end
        end
    end

    assign bus.gnt      = w_gnt;
    assign bus.rom_addr = r_rom_addr;
    assign bus.rdata    = r_rdata;
    assign bus.rvalid   = r_rvalid;

endmodule
`default_nettype wire

// File: tb/tb_card_rom_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_card_rom_arbiter
//  Description : Self-checking bench for card_rom_arbiter with a behavioural
//                ROM and a transaction-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_card_rom_arbiter;

    localparam int N  = 4;
    localparam int AW = 12;
    localparam int DW = 12;

    logic clk;
    logic rst_n;

    card_rom_arbiter_if #(.N_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    card_rom_arbiter #(.N_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Registered-output card image ROM.
    logic [DW-1:0] mem [0:(1<<AW)-1];
    always @(posedge clk) bus.rom_dout <= mem[bus.rom_addr];

    // Reference model state
    typedef struct {
        int            due;
        int            idx;
        logic [DW-1:0] data;
    } rd_t;

    rd_t           pend[$];
    int            cyc;
    int            m_ptr;
    logic [AW-1:0] m_rom_addr;
    logic [DW-1:0] m_rdata;

    logic [N-1:0]  exp_gnt;
    logic [N-1:0]  exp_rvalid;
    logic [DW-1:0] exp_rdata;
    logic [AW-1:0] exp_rom_addr;

    int n_vec;
    int n_err;

    // One clock cycle: drive inputs, form expectations, advance the model.
    task automatic cycle(input logic [N-1:0] r, input logic [N*AW-1:0] a);
        int w;
        @(negedge clk);
        bus.req  = r;
        bus.addr = a;
        #1;
        exp_rom_addr = m_rom_addr;
        exp_rvalid   = '0;
        if (pend.size() > 0 && pend[0].due == cyc) begin
            exp_rvalid[pend[0].idx] = 1'b1;
            m_rdata = pend[0].data;
            void'(pend.pop_front());
        end
        exp_rdata = m_rdata;
        exp_gnt   = '0;
        w = -1;
        for (int k = 0; k < N; k++) begin
            if (w < 0 && r[(m_ptr + k) % N]) w = (m_ptr + k) % N;
        end
        if (w >= 0) begin
            rd_t e;
            exp_gnt[w] = 1'b1;
            m_rom_addr = a[w*AW +: AW];
            e.due  = cyc + 3;
            e.idx  = w;
            e.data = mem[m_rom_addr];
            pend.push_back(e);
`ifndef CARD_ARB_FIXED_PRIO_EN
            m_ptr = (w + 1) % N;
`endif
        end
        cyc++;
    endtask

    task automatic apply_reset(input int cycles);
        @(negedge clk);
        rst_n    = 1'b0;
        bus.req  = '0;
        pend.delete();
        m_ptr      = 0;
        m_rom_addr = '0;
        m_rdata    = '0;
        #1;
        n_vec++;
        if (bus.rvalid !== '0 || bus.rdata !== '0 || bus.rom_addr !== '0 || bus.gnt !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: rvalid=%h rdata=%h rom_addr=%h gnt=%h, required all 0",
                     bus.rvalid, bus.rdata, bus.rom_addr, bus.gnt);
        end
        repeat (cycles) @(negedge clk);
        rst_n = 1'b1;
        cyc += cycles + 1;
    endtask

    task automatic test_reset();
        apply_reset(2);
        for (int i = 0; i < 10; i++) begin
            cycle('0, '0);
            n_vec++;
            if (bus.gnt !== '0 || bus.rvalid !== '0 || bus.rdata !== '0 || bus.rom_addr !== '0) begin
                n_err++;
                $display("FAIL reset_idle[%0d]: gnt=%h rvalid=%h rdata=%h rom_addr=%h, required 0",
                         i, bus.gnt, bus.rvalid, bus.rdata, bus.rom_addr);
            end
        end
    endtask

    task automatic test_single_read();
        logic [N*AW-1:0] a;
        a = '0;
        a[1*AW +: AW] = 12'h0A5;
        cycle(4'b0010, a);
        n_vec++;
        if (bus.gnt !== 4'b0010) begin
            n_err++;
            $display("FAIL single_gnt: got %b, required 0010", bus.gnt);
        end
        for (int t = 1; t <= 5; t++) begin
            cycle('0, '0);
            n_vec++;
            if (bus.rom_addr !== exp_rom_addr || bus.rvalid !== exp_rvalid || bus.rdata !== exp_rdata) begin
                n_err++;
                $display("FAIL single_t%0d: rom_addr=%h rvalid=%b rdata=%h, required %h %b %h",
                         t, bus.rom_addr, bus.rvalid, bus.rdata, exp_rom_addr, exp_rvalid, exp_rdata);
            end
            if (t == 3) begin
                n_vec++;
                if (bus.rvalid !== 4'b0010 || bus.rdata !== 12'hF0F) begin
                    n_err++;
                    $display("FAIL single_data: rvalid=%b rdata=%h, required 0010 f0f", bus.rvalid, bus.rdata);
                end
            end
        end
    endtask

    task automatic test_round_robin();
        logic [N*AW-1:0] a;
        for (int i = 0; i < N; i++) a[i*AW +: AW] = AW'(i);
        for (int c = 0; c < 8 + 4; c++) begin
            cycle((c < 8) ? 4'b1111 : 4'b0000, a);
            n_vec++;
            if (bus.gnt !== exp_gnt || bus.rvalid !== exp_rvalid || bus.rdata !== exp_rdata || bus.rom_addr !== exp_rom_addr) begin
                n_err++;
                $display("FAIL round_robin[%0d]: gnt=%b rvalid=%b rdata=%h rom_addr=%h, required %b %b %h %h",
                         c, bus.gnt, bus.rvalid, bus.rdata, bus.rom_addr, exp_gnt, exp_rvalid, exp_rdata, exp_rom_addr);
            end
        end
    endtask

    task automatic test_stream();
        logic [N*AW-1:0] a;
        int pulses;
        pulses = 0;
        a = '0;
        for (int c = 0; c < 16 + 4; c++) begin
            a[3*AW +: AW] = AW'(c);
            cycle((c < 16) ? 4'b1000 : 4'b0000, a);
            if (bus.rvalid === 4'b1000) pulses++;
            n_vec++;
            if (bus.gnt !== exp_gnt || bus.rvalid !== exp_rvalid || bus.rdata !== exp_rdata) begin
                n_err++;
                $display("FAIL stream[%0d]: gnt=%b rvalid=%b rdata=%h, required %b %b %h",
                         c, bus.gnt, bus.rvalid, bus.rdata, exp_gnt, exp_rvalid, exp_rdata);
            end
        end
        n_vec++;
        if (pulses != 16) begin
            n_err++;
            $display("FAIL stream_count: got %0d pulses, required 16", pulses);
        end
    endtask

    task automatic test_reset_midflight();
        logic [N*AW-1:0] a;
        a = '0;
        a[2*AW +: AW] = 12'h123;
        cycle(4'b0100, a);
        n_vec++;
        if (bus.gnt !== exp_gnt) begin
            n_err++;
            $display("FAIL midflight_gnt: got %b, required %b", bus.gnt, exp_gnt);
        end
        apply_reset(1);
        for (int c = 0; c < 5; c++) begin
            cycle((c == 0) ? 4'b1111 : 4'b0000, '0);
            n_vec++;
            if (bus.rvalid !== exp_rvalid || bus.gnt !== exp_gnt || bus.rdata !== exp_rdata) begin
                n_err++;
                $display("FAIL midflight[%0d]: rvalid=%b gnt=%b rdata=%h, required %b %b %h",
                         c, bus.rvalid, bus.gnt, bus.rdata, exp_rvalid, exp_gnt, exp_rdata);
            end
        end
    endtask

    task automatic test_wrap_hold();
        logic [N*AW-1:0] a;
        for (int i = 0; i < N; i++) a[i*AW +: AW] = AW'(12'h300 + i);
        cycle(4'b1000, a);
        for (int c = 0; c < 3; c++) begin
            cycle('0, '0);
            n_vec++;
            if (c > 0 && bus.rom_addr !== 12'h303) begin
                n_err++;
                $display("FAIL wrap_hold_addr[%0d]: rom_addr=%h, required 303", c, bus.rom_addr);
            end
        end
        cycle(4'b1001, a);
        n_vec++;
        if (bus.gnt !== exp_gnt) begin
            n_err++;
            $display("FAIL wrap_gnt: got %b, required %b", bus.gnt, exp_gnt);
        end
        for (int c = 0; c < 4; c++) begin
            cycle('0, '0);
            n_vec++;
            if (bus.rvalid !== exp_rvalid || bus.rdata !== exp_rdata) begin
                n_err++;
                $display("FAIL wrap_drain[%0d]: rvalid=%b rdata=%h, required %b %h",
                         c, bus.rvalid, bus.rdata, exp_rvalid, exp_rdata);
            end
        end
    endtask

    task automatic test_random();
        logic [N-1:0]    r;
        logic [N*AW-1:0] a;
        for (int c = 0; c < 400; c++) begin
            r = ($urandom_range(0, 3) == 0) ? '0 : N'($urandom);
            a = (N*AW)'({$urandom, $urandom});
            cycle(r, a);
            n_vec++;
            if (bus.gnt !== exp_gnt || bus.rvalid !== exp_rvalid || bus.rdata !== exp_rdata || bus.rom_addr !== exp_rom_addr) begin
                n_err++;
                $display("FAIL random[%0d]: gnt=%b rvalid=%b rdata=%h rom_addr=%h, required %b %b %h %h",
                         c, bus.gnt, bus.rvalid, bus.rdata, bus.rom_addr, exp_gnt, exp_rvalid, exp_rdata, exp_rom_addr);
            end
        end
        for (int c = 0; c < 4; c++) begin
            cycle('0, '0);
            n_vec++;
            if (bus.rvalid !== exp_rvalid || bus.rdata !== exp_rdata) begin
                n_err++;
                $display("FAIL random_drain[%0d]: rvalid=%b rdata=%h, required %b %h",
                         c, bus.rvalid, bus.rdata, exp_rvalid, exp_rdata);
            end
        end
        n_vec++;
        if (pend.size() != 0) begin
            n_err++;
            $display("FAIL random_outstanding: %0d reads never returned, required 0", pend.size());
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        cyc   = 0;
        m_ptr = 0;
        m_rom_addr = '0;
        m_rdata    = '0;
        rst_n    = 1'b0;
        bus.req  = '0;
        bus.addr = '0;
        for (int i = 0; i < (1 << AW); i++) mem[i] = DW'($urandom);
        mem[12'h0A5] = 12'hF0F;

        test_reset();
        test_single_read();
        test_round_robin();
        test_stream();
        test_reset_midflight();
        test_wrap_hold();
        test_random();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
